// File: rtl/cell_pos_reader_pkg.sv
// Shared cell-memory reader definitions: FSM encoding, FIFO depth and read latency.
// Imported by the reader top and its position FIFO.
package cell_pos_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_CNT   = 3'd1,
        ST_WAIT_CNT = 3'd2,
        ST_STREAM   = 3'd3,
        ST_DONE     = 3'd4
    } rd_state_t;

    localparam int POS_FIFO_DEPTH = 4;
    localparam int MEM_RD_LATENCY = 2;

endpackage

// File: rtl/cell_pos_reader_fifo.sv
// Small position FIFO: first-word-fall-through head, push/pop, full/empty and occupancy.
module pos_read_fifo
    import cell_pos_reader_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = POS_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = storage[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push)
            storage[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cell_pos_reader.sv
// Streams the {posz,posy,posx} words of one cell: reads the count at address 0,
// then addresses 1..count with credit-limited reads into a 4-entry FIFO.
//
// state       | meaning
// ST_IDLE     | waiting for start
// ST_RD_CNT   | read of address 0 on the memory port
// ST_WAIT_CNT | memory latency, count latched on the last cycle
// ST_STREAM   | issuing position reads and draining beats
// ST_DONE     | one-cycle done pulse
module cell_pos_reader
    import cell_pos_reader_pkg::*;
#(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last
);
    localparam int FIFO_W = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam int CNT_W  = $clog2(POS_FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    rd_state_t             state;
    logic [1:0]            wait_cnt;
    logic [ADDR_WIDTH:0]   next_addr;
    logic                  strm_rd;
    logic                  strm_rd_d1;
    logic                  strm_rd_d2;
    logic [ADDR_WIDTH-1:0] idx_d1;
    logic [ADDR_WIDTH-1:0] idx_d2;

    logic [ADDR_WIDTH-1:0] cnt_raw;
    logic [ADDR_WIDTH-1:0] cnt_clamped;
    logic [3:0]            pending;
    logic                  issue;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FIFO_W-1:0]     fifo_head;
    logic [CNT_W-1:0]      fifo_count;

    assign cnt_raw     = mem_q[ADDR_WIDTH-1:0];
    assign cnt_clamped = (cnt_raw > MAX_COUNT) ? MAX_COUNT : cnt_raw;

    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
    assign out_index = out_valid ? fifo_head[DATA_WIDTH +: ADDR_WIDTH] : '0;
    assign out_last  = out_valid && fifo_head[FIFO_W-1];
    assign pop       = out_valid && out_ready;
    assign mem_wren  = 1'b0;

    // Reads in flight plus buffered beats as they will stand in the next cycle.
    assign pending = 4'(strm_rd) + 4'(strm_rd_d1) + 4'(strm_rd_d2) + 4'(fifo_count) - 4'(pop);
    assign issue   = (state == ST_STREAM) && (next_addr <= {1'b0, particle_count})
                     && (pending < 4'(POS_FIFO_DEPTH)) && !fifo_full;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            particle_count <= '0;
            mem_address    <= '0;
            mem_rden       <= 1'b0;
            strm_rd        <= 1'b0;
            wait_cnt       <= '0;
            next_addr      <= '0;
        end else begin
            mem_rden <= 1'b0;
            strm_rd  <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_RD_CNT;
                        busy        <= 1'b1;
                        mem_rden    <= 1'b1;
                        mem_address <= '0;
                    end
                end
                ST_RD_CNT: begin
                    state    <= ST_WAIT_CNT;
                    wait_cnt <= 2'(MEM_RD_LATENCY - 1);
                end
                ST_WAIT_CNT: begin
                    if (wait_cnt == '0) begin
                        particle_count <= cnt_clamped;
                        if (cnt_clamped == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= ST_STREAM;
                            mem_rden    <= 1'b1;
                            strm_rd     <= 1'b1;
                            mem_address <= ADDR_WIDTH'(1);
                            next_addr   <= (ADDR_WIDTH + 1)'(2);
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (issue) begin
                        mem_rden    <= 1'b1;
                        strm_rd     <= 1'b1;
                        mem_address <= next_addr[ADDR_WIDTH-1:0];
                        next_addr   <= next_addr + 1'b1;
                    end
                    if (pop && out_last) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Tags follow each position read through the memory latency; reset drops late data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            strm_rd_d1 <= 1'b0;
            strm_rd_d2 <= 1'b0;
            idx_d1     <= '0;
            idx_d2     <= '0;
        end else begin
            strm_rd_d1 <= strm_rd;
            strm_rd_d2 <= strm_rd_d1;
            idx_d1     <= mem_address;
            idx_d2     <= idx_d1;
        end
    end

    pos_read_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (POS_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (strm_rd_d2),
        .push_data ({(idx_d2 == particle_count), idx_d2, mem_q}),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_cell_pos_reader.sv
// Randomized bench for cell_pos_reader: memory model with 2-cycle latency and
// an expected-beat queue built directly from the cell contents.
module tb_cell_pos_reader;
    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, done, mem_rden, mem_wren, out_valid, out_last;
    logic [AW-1:0] particle_count, mem_address, out_index;
    logic [DW-1:0] mem_q = '0;
    logic [DW-1:0] out_data;
    logic [DW-1:0] q_stage = '0;
    logic [DW-1:0] mem_words [256];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int exp_idx[$];
    logic [DW-1:0] exp_dat[$];
    int exp_count = 0;
    int beats = 0, done_pulses = 0, strm_reads = 0, next_rd = 1, last_idx = 0;
    int start_cyc = 0, first_beat_cyc = 0, last_beat_cyc = 0, done_cyc = 0;
    int ready_mode = 0, rdy_phase = 0;
    logic          prev_stall = 1'b0;
    logic          prev_last = 1'b0;
    logic [AW-1:0] prev_idx = '0;
    logic [DW-1:0] prev_data = '0;

    always #5 clk = ~clk;

    cell_pos_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .particle_count(particle_count), .mem_address(mem_address),
        .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Cell memory: data appears two cycles after the rden cycle.
    always @(posedge clk) begin
        q_stage <= mem_rden ? mem_words[mem_address] : {3{32'hdead_beef}};
        mem_q   <= q_stage;
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (rdy_phase % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        rdy_phase++;
    end

    // Monitor: negedge sees exactly what the next rising edge will see.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            exp_idx.delete();
            exp_dat.delete();
            prev_stall = 1'b0;
        end else begin
            if (mem_rden) check("wren_zero", mem_wren, 1'b0);
            if (mem_rden && mem_address != '0) begin
                check("rd_addr", mem_address, next_rd);
                check("rd_credit", (strm_reads - beats) < 4, 1'b1);
                next_rd++;
                strm_reads++;
            end
            if (prev_stall) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_index", out_index, prev_idx);
                check("hold_data", out_data, prev_data);
                check("hold_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                if (exp_idx.size() == 0) begin
                    check("extra_beat", out_index, 0);
                end else begin
                    check("beat_index", out_index, exp_idx[0]);
                    check("beat_data", out_data, exp_dat[0]);
                    check("beat_last", out_last, exp_idx[0] == exp_count);
                    void'(exp_idx.pop_front());
                    void'(exp_dat.pop_front());
                end
                if (beats == 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                last_idx = int'(out_index);
                beats++;
            end
            prev_stall = out_valid && !out_ready;
            prev_idx   = out_index;
            prev_data  = out_data;
            prev_last  = out_last;
            if (done) begin
                done_pulses++;
                done_cyc = cyc;
            end
        end
    end

    task automatic load_cell(input int cnt_field, input bit fill_random);
        mem_words[0] = DW'(cnt_field);
        for (int k = 1; k < 256; k++)
            mem_words[k] = fill_random ? {$urandom(), $urandom(), $urandom()}
                                       : {32'(k), 32'(k), 32'(k)};
        exp_count = (cnt_field > PN - 1) ? PN - 1 : cnt_field;
        exp_idx.delete();
        exp_dat.delete();
        for (int i = 1; i <= exp_count; i++) begin
            exp_idx.push_back(i);
            exp_dat.push_back(mem_words[i]);
        end
        beats = 0; done_pulses = 0; strm_reads = 0; next_rd = 1; rdy_phase = 0;
    endtask

    task automatic run_cell(input int cnt_field, input int mode, input bit fill_random,
                            input bit restart_pulse);
        int budget;
        ready_mode = mode;
        load_cell(cnt_field, fill_random);
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        budget = 0;
        while (done_pulses == 0 && budget < 3000) begin
            @(posedge clk); #1;
            budget++;
            start = restart_pulse && (budget == 6);
        end
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("no_timeout", budget < 3000, 1'b1);
        check("done_pulses", done_pulses, 1);
        check("beat_count", beats, exp_count);
        check("particle_count", particle_count, exp_count);
        check("leftover", exp_idx.size(), 0);
        check("stream_reads", strm_reads, exp_count);
        check("busy_after", busy, 1'b0);
        if (exp_count == 0) begin
            check("done_lat_zero", done_cyc - start_cyc, 4);
        end else begin
            check("last_index", last_idx, exp_count);
            check("done_after_last", done_cyc - last_beat_cyc, 1);
            if (mode == 0) begin
                check("first_beat_lat", first_beat_cyc - start_cyc, 7);
                check("back_to_back", last_beat_cyc - first_beat_cyc, exp_count - 1);
            end
        end
    endtask

    task automatic reset_mid_stream();
        int budget;
        logic seen;
        ready_mode = 0;
        load_cell(10, 1'b0);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        budget = 0;
        while (!(out_valid && out_index == 3) && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        check("third_beat_seen", budget < 200, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_last", out_last, 1'b0);
        check("rst_rden", mem_rden, 1'b0);
        check("rst_addr", mem_address, 0);
        check("rst_count", particle_count, 0);
        check("rst_index", out_index, 0);
        check("rst_data", out_data, 0);
        rst = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | out_valid | mem_rden;
        end
        check("late_data_dropped", seen, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("init_busy", busy, 1'b0);
        check("init_done", done, 1'b0);
        check("init_valid", out_valid, 1'b0);
        check("init_rden", mem_rden, 1'b0);
        check("init_addr", mem_address, 0);
        check("init_count", particle_count, 0);
        rst = 1'b1;

        run_cell(5, 0, 1'b0, 1'b0);
        run_cell(0, 0, 1'b0, 1'b0);
        run_cell(5, 1, 1'b0, 1'b0);
        run_cell(255, 0, 1'b1, 1'b0);
        reset_mid_stream();
        run_cell(10, 0, 1'b0, 1'b0);
        run_cell(12, 2, 1'b1, 1'b1);
        run_cell(4, 1, 1'b1, 1'b1);
        for (int r = 0; r < 6; r++)
            run_cell(int'($urandom_range(0, 255)), int'($urandom_range(0, 2)), 1'b1, 1'b0);
        run_cell(1, 2, 1'b1, 1'b0);
        run_cell(219, 2, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
